// File: rtl/riscvsys_evcnt.sv
// Windowed event counter bank: counts evmon strobes per window of enabled
// cycles, snapshots the counts at window end and drains them one beat per event.
module riscvsys_evcnt #(
  parameter int N_EV   = 8,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  localparam int IDX_W = $clog2(N_EV)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [N_EV-1:0]  i_ev,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [IDX_W-1:0] o_idx,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last,
  output logic [15:0]      o_window,
  output logic             o_drop,
  output logic             o_busy
);

  localparam int WT_W = $clog2(WINDOW);
  localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_EV - 1);
  localparam logic [CNT_W-1:0] CMAX     = '1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t           st_q, st_d;
  logic [WT_W-1:0]  wt_q, wt_d;
  logic [CNT_W-1:0] cnt_q  [N_EV];
  logic [CNT_W-1:0] cnt_d  [N_EV];
  logic [CNT_W-1:0] snap_q [N_EV];
  logic [CNT_W-1:0] snap_d [N_EV];
  logic [CNT_W-1:0] nxt    [N_EV];
  logic [15:0]      seq_q, seq_d;
  logic [15:0]      win_q, win_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             drop_q, drop_d;
  logic             we, last, acc, cap;

  always_comb begin
    we   = i_en && (wt_q == WT_LAST);
    last = (idx_q == IDX_LAST);
    acc  = (st_q == DRAIN) && i_ready;

    wt_d = wt_q;
    if (i_en) wt_d = we ? '0 : wt_q + 1'b1;

    // nxt includes the strobe of this cycle, so the we-cycle event
    // lands in the closing window's snapshot
    for (int i = 0; i < N_EV; i++) begin
      nxt[i] = (i_ev[i] && cnt_q[i] != CMAX) ? cnt_q[i] + 1'b1 : cnt_q[i];
      cnt_d[i] = cnt_q[i];
      if (i_en) cnt_d[i] = we ? '0 : nxt[i];
    end

    seq_d  = we ? seq_q + 16'd1 : seq_q;
    snap_d = snap_q;
    win_d  = win_q;
    idx_d  = idx_q;
    st_d   = st_q;
    drop_d = drop_q;
    cap    = 1'b0;

    unique case (st_q)
      IDLE: cap = we;
      DRAIN: begin
        if (acc && last) begin
          if (we) cap = 1'b1;
          else st_d = IDLE;
        end else begin
          if (acc) idx_d = idx_q + 1'b1;
          if (we) drop_d = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase

    if (cap) begin
      snap_d = nxt;
      win_d  = seq_q;
      idx_d  = '0;
      st_d   = DRAIN;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q   <= IDLE;
      wt_q   <= '0;
      seq_q  <= '0;
      win_q  <= '0;
      idx_q  <= '0;
      drop_q <= 1'b0;
      for (int i = 0; i < N_EV; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      st_q   <= st_d;
      wt_q   <= wt_d;
      seq_q  <= seq_d;
      win_q  <= win_d;
      idx_q  <= idx_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end

  assign o_valid  = (st_q == DRAIN);
  assign o_busy   = (st_q == DRAIN);
  assign o_idx    = idx_q;
  assign o_cnt    = snap_q[idx_q];
  assign o_last   = (st_q == DRAIN) && last;
  assign o_window = win_q;
  assign o_drop   = drop_q;

endmodule

// File: tb/tb_riscvsys_evcnt.sv
// Directed bench for riscvsys_evcnt: three parameterisations share stimulus,
// each test resets and checks the instance it targets.
module tb_riscvsys_evcnt;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] ev;
  logic       rdy;

  logic a_valid, a_last, a_drop, a_busy;
  logic [1:0] a_idx;
  logic [7:0] a_cnt;
  logic [15:0] a_win;

  logic b_valid, b_last, b_drop, b_busy;
  logic [1:0] b_idx;
  logic [3:0] b_cnt;
  logic [15:0] b_win;

  logic c_valid, c_last, c_drop, c_busy;
  logic [1:0] c_idx;
  logic [7:0] c_cnt;
  logic [15:0] c_win;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  riscvsys_evcnt #(.N_EV(4), .CNT_W(8), .WINDOW(16)) u_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_ev(ev),
    .o_valid(a_valid), .i_ready(rdy), .o_idx(a_idx), .o_cnt(a_cnt),
    .o_last(a_last), .o_window(a_win), .o_drop(a_drop), .o_busy(a_busy)
  );

  riscvsys_evcnt #(.N_EV(4), .CNT_W(4), .WINDOW(32)) u_b (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_ev(ev),
    .o_valid(b_valid), .i_ready(rdy), .o_idx(b_idx), .o_cnt(b_cnt),
    .o_last(b_last), .o_window(b_win), .o_drop(b_drop), .o_busy(b_busy)
  );

  riscvsys_evcnt #(.N_EV(4), .CNT_W(8), .WINDOW(6)) u_c (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_ev(ev),
    .o_valid(c_valid), .i_ready(rdy), .o_idx(c_idx), .o_cnt(c_cnt),
    .o_last(c_last), .o_window(c_win), .o_drop(c_drop), .o_busy(c_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    ev  = '0;
    rdy = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic v, input int idx,
                       input int cnt, input logic l, input int win);
    chk({tag, ".valid"}, 32'(a_valid), 32'(v));
    chk({tag, ".busy"},  32'(a_busy),  32'(v));
    chk({tag, ".idx"},   32'(a_idx),   idx);
    chk({tag, ".cnt"},   32'(a_cnt),   cnt);
    chk({tag, ".last"},  32'(a_last),  32'(l));
    chk({tag, ".win"},   32'(a_win),   win);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    ev  = '0;
    rdy = 1'b0;
    cyc();
    cyc();
    chk_a("rst", 1'b0, 0, 0, 1'b0, 0);
    chk("rst.drop", 32'(a_drop), 0);
    rst = 1'b0;

    // T1: ev0 every cycle for one 16-cycle window
    en = 1'b1; ev = 4'b0001; rdy = 1'b1;
    repeat (15) cyc();
    chk("t1.early", 32'(a_valid), 0);
    cyc();
    ev = 4'b0000;
    chk_a("t1.b0", 1'b1, 0, 16, 1'b0, 0);
    cyc();
    chk_a("t1.b1", 1'b1, 1, 0, 1'b0, 0);
    cyc();
    chk_a("t1.b2", 1'b1, 2, 0, 1'b0, 0);
    cyc();
    chk_a("t1.b3", 1'b1, 3, 0, 1'b1, 0);
    cyc();
    chk("t1.idle", 32'(a_valid), 0);

    // T2: 4-bit counter saturates at 15
    do_reset();
    en = 1'b1; ev = 4'b0010; rdy = 1'b1;
    repeat (32) cyc();
    ev = 4'b0000;
    chk("t2.v",    32'(b_valid), 1);
    chk("t2.c0",   32'(b_cnt), 0);
    cyc();
    chk("t2.i1",   32'(b_idx), 1);
    chk("t2.c1",   32'(b_cnt), 15);
    cyc();
    chk("t2.c2",   32'(b_cnt), 0);
    cyc();
    chk("t2.c3",   32'(b_cnt), 0);
    chk("t2.last", 32'(b_last), 1);

    // T3: stall through a second window end -> drop
    do_reset();
    en = 1'b1;
    for (int c = 0; c <= 49; c++) begin
      ev  = (c % 16 == 3) ? 4'b0100 : 4'b0000;
      rdy = (c >= 41);
      cyc();
      if (c == 15) chk_a("t3.first", 1'b1, 0, 0, 1'b0, 0);
      if (c == 30) chk("t3.nodrop", 32'(a_drop), 0);
      if (c == 31) chk("t3.drop", 32'(a_drop), 1);
      if (c == 40) chk_a("t3.stall", 1'b1, 0, 0, 1'b0, 0);
      if (c == 42) chk_a("t3.i2", 1'b1, 2, 1, 1'b0, 0);
      if (c == 44) chk("t3.idle", 32'(a_valid), 0);
      if (c == 47) chk_a("t3.w2", 1'b1, 0, 0, 1'b0, 2);
      if (c == 49) chk_a("t3.w2i2", 1'b1, 2, 1, 1'b0, 2);
    end
    chk("t3.sticky", 32'(a_drop), 1);

    // T4: ev3 on last cycle of window 0 and first of window 1
    do_reset();
    en = 1'b1; rdy = 1'b1;
    for (int c = 0; c <= 34; c++) begin
      ev = (c == 15 || c == 16) ? 4'b1000 : 4'b0000;
      cyc();
      if (c == 18) chk_a("t4.w0", 1'b1, 3, 1, 1'b1, 0);
      if (c == 31) chk_a("t4.w1b0", 1'b1, 0, 0, 1'b0, 1);
      if (c == 34) chk_a("t4.w1", 1'b1, 3, 1, 1'b1, 1);
    end

    // T5: enable gap delays window end; then reset mid-drain
    do_reset();
    rdy = 1'b1; ev = 4'b1111;
    for (int c = 0; c <= 21; c++) begin
      en = !(c >= 8 && c <= 12);
      cyc();
      if (c == 15) chk("t5.noend", 32'(a_valid), 0);
      if (c == 19) chk("t5.noend2", 32'(a_valid), 0);
      if (c == 20) chk_a("t5.b0", 1'b1, 0, 16, 1'b0, 0);
      if (c == 21) chk_a("t5.b1", 1'b1, 1, 16, 1'b0, 0);
    end
    rst = 1'b1;
    #1;
    chk("t5.async", 32'(a_valid), 0);
    cyc();
    rst = 1'b0;
    en = 1'b1; ev = 4'b0000;
    repeat (16) cyc();
    chk_a("t5.restart", 1'b1, 0, 0, 1'b0, 0);

    // T6: WINDOW=6, last accept coincides with next window end
    do_reset();
    en = 1'b1; ev = 4'b0001;
    for (int c = 0; c <= 17; c++) begin
      rdy = !(c == 6 || c == 7);
      cyc();
      if (c == 5) begin
        chk("t6.v0", 32'(c_valid), 1);
        chk("t6.c0", 32'(c_cnt), 6);
      end
      if (c == 10) chk("t6.last", 32'(c_last), 1);
      if (c == 11) begin
        chk("t6.nobubble", 32'(c_valid), 1);
        chk("t6.idx", 32'(c_idx), 0);
        chk("t6.win", 32'(c_win), 1);
        chk("t6.cnt", 32'(c_cnt), 6);
        chk("t6.nodrop", 32'(c_drop), 0);
      end
      if (c == 16) chk("t6.gap", 32'(c_valid), 0);
      if (c == 17) begin
        chk("t6.w2", 32'(c_win), 2);
        chk("t6.drop", 32'(c_drop), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
